// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forward-select encoding,
// the shadow record of one pipeline stage, and small match helpers.
package hazard_pkg;

  // Widest register address the shadow records can hold; narrower
  // addresses are zero-extended into these fields.
  localparam int HZ_AW = 8;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic [HZ_AW-1:0] rs1;
    logic [HZ_AW-1:0] rs2;
    logic [HZ_AW-1:0] rd;
    logic             regwrite;
    logic             load;
  } hz_rec_t;

  localparam hz_rec_t HZ_BUBBLE = '{
    rs1:      {HZ_AW{1'b0}},
    rs2:      {HZ_AW{1'b0}},
    rd:       {HZ_AW{1'b0}},
    regwrite: 1'b0,
    load:     1'b0
  };

  // True when a stage writes a nonzero register equal to source register src.
  function automatic logic wr_hit(input hz_rec_t r, input logic [HZ_AW-1:0] src);
    return r.regwrite && (r.rd != {HZ_AW{1'b0}}) && (r.rd == src);
  endfunction

  // Operand select for one source in E; the M stage holds the younger
  // producer so it wins over W. Source x0 always reads the register file.
  function automatic fwd_sel_t fwd_pick(input logic [HZ_AW-1:0] src,
                                        input hz_rec_t m, input hz_rec_t w);
    fwd_sel_t sel;
    if (src == {HZ_AW{1'b0}}) begin
      sel = FWD_RF;
    end else if (wr_hit(m, src)) begin
      sel = FWD_MEM;
    end else if (wr_hit(w, src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-stage fields in, forward selects and stall/flush lines out.
interface hazard_ctrl_if #(parameter int REG_AW = 5);
  logic [REG_AW-1:0] Rs1D;
  logic [REG_AW-1:0] Rs2D;
  logic [REG_AW-1:0] RdD;
  logic              RegWriteD;
  logic              LoadD;
  logic              PCSrcE;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              StallF;
  logic              StallD;
  logic              FlushD;
  logic              FlushE;

  // Datapath side
  modport master (
    output Rs1D, Rs2D, RdD, RegWriteD, LoadD, PCSrcE,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE
  );

  // Hazard controller side
  modport slave (
    input  Rs1D, Rs2D, RdD, RegWriteD, LoadD, PCSrcE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE
  );
endinterface

// File: rtl/hazard_rec_reg.sv
// One shadow-record pipeline register with synchronous reset and
// flush-to-bubble.
module hazard_rec_reg
  import hazard_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    flush,
  input  hz_rec_t d,
  output hz_rec_t q
);

  // Advance the record each cycle; reset or flush inserts a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= HZ_BUBBLE;
    end else if (flush) begin
      q <= HZ_BUBBLE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: keeps shadow records of the instructions in
// E, M and W and derives operand forwarding plus stall/flush controls.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  hz_rec_t rec_d_s;
  hz_rec_t rec_e_r;
  hz_rec_t rec_m_r;
  hz_rec_t rec_w_r;
  logic    lu_stall_s;
  logic    flush_e_s;

  // Widen the decode-stage fields into a record for the E register.
  always_comb begin
    rec_d_s                  = HZ_BUBBLE;
    rec_d_s.rs1[REG_AW-1:0]  = hz.Rs1D;
    rec_d_s.rs2[REG_AW-1:0]  = hz.Rs2D;
    rec_d_s.rd[REG_AW-1:0]   = hz.RdD;
    rec_d_s.regwrite         = hz.RegWriteD;
    rec_d_s.load             = hz.LoadD;
  end

  hazard_rec_reg u_rec_e (
    .clk   (clk),
    .reset (reset),
    .flush (flush_e_s),
    .d     (rec_d_s),
    .q     (rec_e_r)
  );

  hazard_rec_reg u_rec_m (
    .clk   (clk),
    .reset (reset),
    .flush (1'b0),
    .d     (rec_e_r),
    .q     (rec_m_r)
  );

  hazard_rec_reg u_rec_w (
    .clk   (clk),
    .reset (reset),
    .flush (1'b0),
    .d     (rec_m_r),
    .q     (rec_w_r)
  );

  // Operand-mux selects for E; without forwarding the register file is
  // always read and hazards are resolved by stalling instead.
  always_comb begin
    if (FWD_EN) begin
      hz.ForwardAE = fwd_pick(rec_e_r.rs1, rec_m_r, rec_w_r);
      hz.ForwardBE = fwd_pick(rec_e_r.rs2, rec_m_r, rec_w_r);
    end else begin
      hz.ForwardAE = FWD_RF;
      hz.ForwardBE = FWD_RF;
    end
  end

  // Stall detection and stall/flush control; a redirect discards D, so it
  // overrides any stall.
  always_comb begin
    lu_stall_s = rec_e_r.load && (rec_e_r.rd != {HZ_AW{1'b0}}) &&
                 ((rec_e_r.rd == rec_d_s.rs1) || (rec_e_r.rd == rec_d_s.rs2));
    if (!FWD_EN) begin
      // W writes the register file in the first half-cycle, so only E and M
      // producers have to drain before D may read.
      lu_stall_s = lu_stall_s ||
                   wr_hit(rec_e_r, rec_d_s.rs1) || wr_hit(rec_e_r, rec_d_s.rs2) ||
                   wr_hit(rec_m_r, rec_d_s.rs1) || wr_hit(rec_m_r, rec_d_s.rs2);
    end else begin
      lu_stall_s = lu_stall_s;
    end
    flush_e_s  = lu_stall_s || hz.PCSrcE;
    hz.StallF  = lu_stall_s && !hz.PCSrcE;
    hz.StallD  = lu_stall_s && !hz.PCSrcE;
    hz.FlushD  = hz.PCSrcE;
    hz.FlushE  = flush_e_s;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage core. It drives the 2-bit selects of the execute-stage operand muxes (`ForwardAE`/`ForwardBE` into the 3-input muxes) and the stall/flush lines of the fetch, decode and execute pipeline registers. It keeps its own shadow record of register-file writers in E, M and W, so the datapath only supplies decode-stage fields and the branch-taken strobe.

## Interface
Parameters:
- `REG_AW`, default 5: register-address width.
- `FWD_EN`, default 1: 1 resolves RAW hazards by forwarding; 0 resolves every RAW hazard by stalling.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: rising-edge clock.
- `reset`, in, 1: synchronous, active-high. Clears all shadow records.
- `Rs1D`, `Rs2D`, in, REG_AW each: source registers of the instruction in D.
- `RdD`, in, REG_AW: destination register of the instruction in D.
- `RegWriteD`, in, 1: the instruction in D writes the register file.
- `LoadD`, in, 1: the instruction in D is a load (result comes from memory).
- `PCSrcE`, in, 1: taken branch or jump resolved in E.
- `ForwardAE`, `ForwardBE`, out, 2 each: select for operand A / operand B in E.
- `StallF`, `StallD`, out, 1 each: hold the PC / hold the IF/ID register.
- `FlushD`, `FlushE`, out, 1 each: clear IF/ID / clear ID/EX to a bubble.

## Operation
- **Shadow records.** There are three records, E, M and W. Each is {rs1, rs2, rd, regwrite, load}; M and W use only rd and regwrite.
- **Per-cycle record update:**
  - W ← M.
  - M ← E.
  - E ← D fields, or ← bubble (regwrite=0, load=0, all fields 0) when `FlushE` is high.
- **Forwarding select encoding:** 2'b00 = register file, 2'b01 = W result, 2'b10 = M ALU result. 2'b11 is never driven.
- **Forwarding for `ForwardAE`** (operand B is identical using rs2):
  - 2'b10 if E.rs1 ≠ 0, M.regwrite = 1 and M.rd = E.rs1.
  - Otherwise 2'b01 if E.rs1 ≠ 0, W.regwrite = 1 and W.rd = E.rs1.
  - Otherwise 2'b00.
  - M has priority over W.
- **Load-use hazard (`luStall`):** asserted when E.load = 1, E.rd ≠ 0, and E.rd equals `Rs1D` or `Rs2D`.
- **`FWD_EN`=0:**
  - Forward outputs are held at 2'b00.
  - `luStall` is widened to any nonzero-rd regwrite match in E or M against `Rs1D`/`Rs2D`.
  - The register file writes in the first half-cycle, so W needs no stall.
- **Control equations:**
  - `StallF` = `StallD` = `luStall` & ~`PCSrcE`.
  - `FlushD` = `PCSrcE`.
  - `FlushE` = `luStall` | `PCSrcE`.
  - A redirect overrides a stall: the instruction in D is being discarded anyway.
- **Register x0:** rd = 0 never forwards and never stalls.

## Timing
- All outputs are combinational from the shadow records plus the D-stage inputs and `PCSrcE`. Latency is zero within the cycle.
- Records update on the rising edge of `clk`.
- **Reset:**
  - While `reset` is high at a clock edge, all three records are cleared to a bubble.
  - In the cycle after reset, `ForwardAE`/`ForwardBE` = 2'b00 and `StallF`/`StallD` = 0.
  - `FlushD`/`FlushE` follow `PCSrcE` only.
- **Reset mid-operation:** any in-flight forward or stall is dropped on the next cycle. No partial state survives.
- **Stall length:** a load-use stall lasts exactly one cycle. The bubble enters E, so the load moves to M and `luStall` deasserts; the consumer then forwards from W (2'b01).
- **With `FWD_EN`=0:** the stall lasts until the producer leaves M, i.e. 1–2 cycles.
- **Simultaneous M and W match on the same register:** select 2'b10 (the youngest producer wins).
- **`PCSrcE` with a pending `luStall`:** no stall; D and E are both flushed in the same cycle.

## Structure
- **Shared package `hazard_pkg`:**
  - `fwd_sel_t` enum: `FWD_RF` = 2'b00, `FWD_WB` = 2'b01, `FWD_MEM` = 2'b10.
  - `hz_rec_t` packed struct for the shadow record.
  - `HZ_BUBBLE` constant.
- **Sub-module `hazard_rec_reg`:** one record register with synchronous reset and flush-to-bubble. It is instantiated three times, for E, M and W.
- Forward select and stall logic sit in the top level, in one always_comb block per output group.

## Test plan
- **ALU→ALU back-to-back:** `add x5` then `sub` using rs1=x5.
  - Required: `ForwardAE`=2'b10 in the consumer's E cycle, no stall.
  - Next independent instruction: 2'b00.
- **Distance-2 dependency:** x7 written, one unrelated instruction between, then used as rs2.
  - Required: `ForwardBE`=2'b01.
  - With x7 also written in M: `ForwardBE`=2'b10.
- **Load-use:** `lw x3` then `add` using rs1=x3.
  - Required: `StallF`=`StallD`=`FlushE`=1 for exactly one cycle, then `ForwardAE`=2'b01.
  - Repeat with rd=x0: no stall, select 2'b00.
- **Branch redirect:** `PCSrcE`=1 while a load-use condition is present.
  - Required: `FlushD`=`FlushE`=1, `StallF`=`StallD`=0.
  - Next cycle: E record is a bubble and all selects are 2'b00.
- **`FWD_EN`=0:** ALU producer x9 immediately consumed.
  - Required: stall of 2 cycles; forward outputs constant 2'b00.
- **Reset mid-stream:** assert `reset` for one cycle while M holds a write to x4 and E reads x4.
  - Required: the following cycle shows all outputs 0 with `PCSrcE`=0, and no forward toward x4.
